// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port data RAM between instruction fetch and the memory stage.
// Define MEM_ARB_STATS_EN to add the grant and stall statistics counters.
module mem_port_arbiter #(
    parameter int unsigned RAM_LAT    = 2,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        f_req,
    input  logic [31:0] f_addr,
    output logic [31:0] f_rdata,
    output logic        f_done,
    input  logic        d_req,
    input  logic        d_rw,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_done,
    output logic        ram_en,
    output logic        ram_rw,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
    output logic        busy
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [15:0] f_grant_cnt,
    output logic [15:0] d_grant_cnt,
    output logic [15:0] stall_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_F,
        OWN_D
    } owner_t;

    localparam logic [3:0] LAT_LOAD   = 4'(RAM_LAT - 1);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t      state_q;
    owner_t      owner_q;
    logic [3:0]  wait_q;
    logic [3:0]  starve_q;
    logic [31:0] f_rdata_q;
    logic [31:0] d_rdata_q;
    logic        f_done_q;
    logic        d_done_q;
    logic        ram_en_q;
    logic        ram_rw_q;
    logic [31:0] ram_addr_q;
    logic [31:0] ram_wdata_q;
    logic        busy_q;

    logic starve_force;
    logic grant_f;
    logic grant_d;

    // A starved fetch beats data only when forcing is enabled and the limit is reached.
    assign starve_force = (STARVE_MAX != 0) && (starve_q == STARVE_LIM);
    assign grant_f      = (state_q == ST_IDLE) && f_req && (!d_req || starve_force);
    assign grant_d      = (state_q == ST_IDLE) && d_req && !grant_f;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only; the synchronous reset branch comes first so every register, including the rdata holders, starts defined.
        if (reset) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_NONE;
            wait_q      <= 4'd0;
            starve_q    <= 4'd0;
            f_rdata_q   <= 32'd0;
            d_rdata_q   <= 32'd0;
            f_done_q    <= 1'b0;
            d_done_q    <= 1'b0;
            ram_en_q    <= 1'b0;
            ram_rw_q    <= 1'b1;
            ram_addr_q  <= 32'd0;
            ram_wdata_q <= 32'd0;
            busy_q      <= 1'b0;
        end else begin
            f_done_q <= 1'b0;
            d_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (grant_f) begin
                        state_q    <= ST_ACCESS;
                        owner_q    <= OWN_F;
                        wait_q     <= LAT_LOAD;
                        ram_en_q   <= 1'b1;
                        ram_rw_q   <= 1'b1;
                        ram_addr_q <= f_addr;
                        busy_q     <= 1'b1;
                        starve_q   <= 4'd0;
                    end else if (grant_d) begin
                        state_q     <= ST_ACCESS;
                        owner_q     <= OWN_D;
                        wait_q      <= LAT_LOAD;
                        ram_en_q    <= 1'b1;
                        ram_rw_q    <= d_rw;
                        ram_addr_q  <= d_addr;
                        ram_wdata_q <= d_wdata;
                        busy_q      <= 1'b1;
                        if (!f_req) begin
                            starve_q <= 4'd0;
                        end else if (starve_q != 4'hF) begin
                            starve_q <= starve_q + 4'd1;
                        end
                    end else if (!f_req) begin
                        starve_q <= 4'd0;
                    end
                end
                ST_ACCESS: begin
                    if (wait_q == 4'd0) begin
                        state_q  <= ST_DONE;
                        ram_en_q <= 1'b0;
                        ram_rw_q <= 1'b1;
                        if (owner_q == OWN_F) begin
                            f_rdata_q <= ram_rdata;
                            f_done_q  <= 1'b1;
                        end else begin
                            if (ram_rw_q) begin
                                d_rdata_q <= ram_rdata;
                            end
                            d_done_q <= 1'b1;
                        end
                    end else begin
                        wait_q <= wait_q - 4'd1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    owner_q <= OWN_NONE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    owner_q <= OWN_NONE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign f_rdata   = f_rdata_q;
    assign f_done    = f_done_q;
    assign d_rdata   = d_rdata_q;
    assign d_done    = d_done_q;
    assign ram_en    = ram_en_q;
    assign ram_rw    = ram_rw_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign busy      = busy_q;

`ifdef MEM_ARB_STATS_EN
    logic [15:0] f_grant_cnt_q;
    logic [15:0] d_grant_cnt_q;
    logic [15:0] stall_cnt_q;
    logic        waiting;

    // One stall per cycle in which any requester is pending without owning the RAM.
    assign waiting = (f_req && (owner_q != OWN_F)) || (d_req && (owner_q != OWN_D));

    always_ff @(posedge clk) begin
        if (reset) begin
            f_grant_cnt_q <= 16'd0;
            d_grant_cnt_q <= 16'd0;
            stall_cnt_q   <= 16'd0;
        end else begin
            if (grant_f) begin
                f_grant_cnt_q <= f_grant_cnt_q + 16'd1;
            end
            if (grant_d) begin
                d_grant_cnt_q <= d_grant_cnt_q + 16'd1;
            end
            if (waiting) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
        end
    end

    assign f_grant_cnt = f_grant_cnt_q;
    assign d_grant_cnt = d_grant_cnt_q;
    assign stall_cnt   = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with RAM_LAT=2 and STARVE_MAX=3.
// Define MEM_ARB_STATS_EN to also exercise the statistics counters.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        f_req;
    logic [31:0] f_addr;
    logic [31:0] f_rdata;
    logic        f_done;
    logic        d_req;
    logic        d_rw;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_done;
    logic        ram_en;
    logic        ram_rw;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        busy;
`ifdef MEM_ARB_STATS_EN
    logic [15:0] f_grant_cnt;
    logic [15:0] d_grant_cnt;
    logic [15:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(
        .RAM_LAT    (2),
        .STARVE_MAX (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .f_req     (f_req),
        .f_addr    (f_addr),
        .f_rdata   (f_rdata),
        .f_done    (f_done),
        .d_req     (d_req),
        .d_rw      (d_rw),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_done    (d_done),
        .ram_en    (ram_en),
        .ram_rw    (ram_rw),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .busy      (busy)
`ifdef MEM_ARB_STATS_EN
        ,
        .f_grant_cnt (f_grant_cnt),
        .d_grant_cnt (d_grant_cnt),
        .stall_cnt   (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic xfer(input bit fetch, input logic [31:0] addr);
        if (fetch) begin
            f_req  = 1'b1;
            f_addr = addr;
        end else begin
            d_req  = 1'b1;
            d_rw   = 1'b1;
            d_addr = addr;
        end
        repeat (3) tick();
        f_req = 1'b0;
        d_req = 1'b0;
        tick();
    endtask

    // The two completion pulses must never coincide.
    always @(negedge clk) begin
        if (!reset) begin
            check("done_excl", 32'(f_done & d_done), 32'd0);
        end
    end

    initial begin
        reset     = 1'b1;
        f_req     = 1'b0;
        f_addr    = 32'd0;
        d_req     = 1'b0;
        d_rw      = 1'b1;
        d_addr    = 32'd0;
        d_wdata   = 32'd0;
        ram_rdata = 32'd0;
        tick();
        tick();
        check("rst_ram_en", 32'(ram_en), 32'd0);
        check("rst_ram_rw", 32'(ram_rw), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'({f_done, d_done}), 32'd0);
        check("rst_addr", ram_addr, 32'd0);
        check("rst_rdata", f_rdata | d_rdata, 32'd0);
        reset = 1'b0;
        tick();

        // Data read: RAM data changes between the two access cycles; only the last is captured.
        d_req = 1'b1; d_rw = 1'b1; d_addr = 32'h10; ram_rdata = 32'hBAD0BAD0;
        tick();
        check("rd_en_c1", 32'(ram_en), 32'd1);
        check("rd_addr_c1", ram_addr, 32'h10);
        check("rd_rw_c1", 32'(ram_rw), 32'd1);
        check("rd_busy_c1", 32'(busy), 32'd1);
        tick();
        ram_rdata = 32'hDEADBEEF;
        check("rd_en_c2", 32'(ram_en), 32'd1);
        check("rd_done_c2", 32'(d_done), 32'd0);
        tick();
        check("rd_done", 32'(d_done), 32'd1);
        check("rd_en_done", 32'(ram_en), 32'd0);
        check("rd_data", d_rdata, 32'hDEADBEEF);
        check("rd_busy_done", 32'(busy), 32'd1);
        d_req = 1'b0;
        tick();
        check("rd_done_off", 32'(d_done), 32'd0);
        check("rd_busy_off", 32'(busy), 32'd0);
        check("rd_addr_hold", ram_addr, 32'h10);
        check("rd_data_hold", d_rdata, 32'hDEADBEEF);

        // Store: inputs change mid-access, latched copies must stay on the pins.
        d_req = 1'b1; d_rw = 1'b0; d_addr = 32'h20; d_wdata = 32'h12345678; ram_rdata = 32'hCAFEF00D;
        tick();
        check("wr_rw_c1", 32'(ram_rw), 32'd0);
        check("wr_wdata_c1", ram_wdata, 32'h12345678);
        check("wr_addr_c1", ram_addr, 32'h20);
        d_wdata = 32'd0; d_addr = 32'h99;
        tick();
        check("wr_rw_c2", 32'(ram_rw), 32'd0);
        check("wr_wdata_c2", ram_wdata, 32'h12345678);
        check("wr_addr_c2", ram_addr, 32'h20);
        tick();
        check("wr_done", 32'(d_done), 32'd1);
        check("wr_rw_done", 32'(ram_rw), 32'd1);
        check("wr_rdata_keep", d_rdata, 32'hDEADBEEF);
        d_req = 1'b0;
        tick();
        check("wr_done_off", 32'(d_done), 32'd0);
        check("wr_wdata_hold", ram_wdata, 32'h12345678);

        // Simultaneous requests: data first, fetch in the following IDLE.
        f_req = 1'b1; f_addr = 32'h100; d_req = 1'b1; d_rw = 1'b1; d_addr = 32'h30; ram_rdata = 32'h0000AAAA;
        tick();
        check("sim_first_addr", ram_addr, 32'h30);
        tick();
        tick();
        check("sim_d_done", 32'(d_done), 32'd1);
        check("sim_d_data", d_rdata, 32'h0000AAAA);
        d_req = 1'b0; ram_rdata = 32'h5555BBBB;
        tick();
        check("sim_idle_en", 32'(ram_en), 32'd0);
        check("sim_idle_busy", 32'(busy), 32'd0);
        tick();
        check("sim_f_grant_en", 32'(ram_en), 32'd1);
        check("sim_f_addr", ram_addr, 32'h100);
        tick();
        check("sim_f_not_yet", 32'(f_done), 32'd0);
        tick();
        check("sim_f_done", 32'(f_done), 32'd1);
        check("sim_f_data", f_rdata, 32'h5555BBBB);
        check("sim_d_keep", d_rdata, 32'h0000AAAA);
        f_req = 1'b0;
        tick();
        check("sim_f_done_off", 32'(f_done), 32'd0);

        // Starvation: three data grants, forced fetch, then data wins again after the clear.
        f_req = 1'b1; f_addr = 32'h200; d_req = 1'b1; d_rw = 1'b1; d_addr = 32'h40; ram_rdata = 32'h77;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("stv_en_%0d", i), 32'(ram_en), 32'd1);
            check($sformatf("stv_addr_%0d", i), ram_addr, (i == 3) ? 32'h200 : 32'h40);
            tick();
            tick();
            check($sformatf("stv_fdone_%0d", i), 32'(f_done), (i == 3) ? 32'd1 : 32'd0);
            check($sformatf("stv_ddone_%0d", i), 32'(d_done), (i == 3) ? 32'd0 : 32'd1);
            tick();
        end
        f_req = 1'b0; d_req = 1'b0;
        tick();

        // Reset in the first access cycle abandons the transfer.
        d_req = 1'b1; d_rw = 1'b1; d_addr = 32'h50; ram_rdata = 32'h99;
        tick();
        check("rst_mid_en", 32'(ram_en), 32'd1);
        reset = 1'b1;
        tick();
        check("rst_mid_en_off", 32'(ram_en), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_rw", 32'(ram_rw), 32'd1);
        check("rst_mid_addr", ram_addr, 32'd0);
        check("rst_mid_wdata", ram_wdata, 32'd0);
        check("rst_mid_rdata", f_rdata | d_rdata, 32'd0);
        check("rst_mid_done", 32'({f_done, d_done}), 32'd0);
        reset = 1'b0; d_req = 1'b0;
        tick();
        check("rst_post_done1", 32'({f_done, d_done}), 32'd0);
        tick();
        check("rst_post_done2", 32'({f_done, d_done}), 32'd0);
        check("rst_post_busy", 32'(busy), 32'd0);

`ifdef MEM_ARB_STATS_EN
        // Pair (data then fetch) stalls 5 cycles, each lone transfer stalls its grant cycle.
        f_req = 1'b1; f_addr = 32'h300; d_req = 1'b1; d_rw = 1'b1; d_addr = 32'h60;
        repeat (3) tick();
        d_req = 1'b0;
        repeat (4) tick();
        f_req = 1'b0;
        tick();
        xfer(1'b1, 32'h304);
        xfer(1'b0, 32'h64);
        xfer(1'b0, 32'h68);
        check("st_f_grants", 32'(f_grant_cnt), 32'd2);
        check("st_d_grants", 32'(d_grant_cnt), 32'd3);
        check("st_stalls", 32'(stall_cnt), 32'd8);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port data RAM between two requesters: instruction fetch (read-only) and the memory stage (LDR/STR/ADR traffic).
- Sits between both requesters and the RAM's address / write-data / RW / read-data pins.
- Sequences each access through a fixed-latency RAM window.
- Data requests have priority; a starvation counter periodically forces a fetch grant.

Parameters:
- RAM_LAT, 2, RAM access cycles per transfer (legal range 1..15).
- STARVE_MAX, 3, consecutive data grants lost by a pending fetch before fetch is forced to win; 0 gives pure data priority (no forcing).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- f_req  input  1  fetch request; held high until f_done is seen.
- f_addr  input  32  fetch word address.
- f_rdata  output  32  fetch read data; valid while f_done=1, held afterwards.
- f_done  output  1  one-cycle fetch completion pulse.
- d_req  input  1  data request; held high until d_done is seen.
- d_rw  input  1  1 = read (LDR/ADR), 0 = write (STR).
- d_addr  input  32  data word address.
- d_wdata  input  32  store data.
- d_rdata  output  32  data read data; valid while d_done=1, held afterwards.
- d_done  output  1  one-cycle data completion pulse.
- ram_en  output  1  RAM access strobe.
- ram_rw  output  1  RAM direction, 1 = read, 0 = write.
- ram_addr  output  32  RAM address.
- ram_wdata  output  32  RAM write data.
- ram_rdata  input  32  RAM read data; valid in the last ACCESS cycle.
- busy  output  1  high in ACCESS and DONE.

Behaviour:
- Reset values: all outputs 0, ram_rw=1, state=IDLE, wait counter 0, starve counter 0, owner=none.
- States and transitions:
  - IDLE: samples requests at each edge. On any grant, latch owner, address, rw and wdata, then go to ACCESS. Fetch requests always use ram_rw=1.
  - ACCESS: ram_en=1 and the latched values drive the RAM pins for exactly RAM_LAT cycles. A down-counter is loaded with RAM_LAT-1 on grant. When the counter is 0, the edge captures ram_rdata into the owner's rdata register (reads only) and goes to DONE.
  - DONE: the owner's done=1 for one cycle; ram_en=0; then return to IDLE.
- Latency: grant edge to done = RAM_LAT+1 cycles. Minimum request-to-next-grant spacing is RAM_LAT+2 cycles.
- Requests are sampled only in IDLE. A requester deasserts req on the edge where it sees done=1. If req is still high in IDLE, it is treated as a new request.
- Inputs may change during ACCESS; the latched copies are used.
- Arbitration in IDLE:
  - Only one requester: grant it.
  - Both requesting: grant data, unless STARVE_MAX != 0 and the starve counter = STARVE_MAX, in which case grant fetch.
- Starve counter (4 bit, saturating):
  - Increments on each data grant while f_req=1.
  - Clears on any fetch grant, or in any IDLE cycle with f_req=0.
- Writes: d_rdata is unchanged. ram_wdata holds the latched d_wdata for the whole ACCESS window.
- Outside ACCESS: ram_addr and ram_wdata hold their last values, and ram_rw returns to 1.
- Reset asserted mid-ACCESS or mid-DONE: the transfer is abandoned; no done pulse; ram_en=0 on the next cycle; rdata registers cleared.
- f_done and d_done are never high in the same cycle.
- The rdata registers change only on their own completed reads.

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- When defined:
  - Adds outputs f_grant_cnt[15:0] and d_grant_cnt[15:0], which increment on each fetch or data grant.
  - Adds stall_cnt[15:0], which increments in every cycle where a requester is high but not owner.
  - All three counters wrap at 0xFFFF to 0 and are cleared by reset.
- When undefined: none of these ports or registers exist, and behaviour is otherwise identical.

Test Plan:
- Data read, RAM_LAT=2: d_req=1, d_rw=1, d_addr=0x10, RAM returns 0xDEADBEEF. Required: ram_en high for 2 cycles with ram_addr=0x10, ram_rw=1; d_done pulses at grant+3; d_rdata=0xDEADBEEF.
- Store: d_rw=0, d_addr=0x20, d_wdata=0x12345678. Required: ram_rw=0 and ram_wdata=0x12345678 for 2 cycles; d_done pulses once; d_rdata unchanged.
- Simultaneous requests: f_req and d_req raised in the same cycle. Required: data is granted first; fetch is granted in the IDLE after d_done; f_done arrives 4 cycles after d_done.
- Starvation, STARVE_MAX=3: f_req held high while d_req is re-raised after every d_done. Required: three data grants, then a fetch grant, then the counter is cleared.
- Reset mid-ACCESS: reset=1 in the first ACCESS cycle. Required: next cycle ram_en=0, busy=0, no done pulse, all outputs at reset values.
- MEM_ARB_STATS_EN: 2 fetch and 3 data transfers. Required: f_grant_cnt=2, d_grant_cnt=3; stall_cnt equals the count of waiting cycles.
